// File: rtl/fetch_buffer_pkg.sv
// fetch_buffer_pkg
//   Shared constants for the instruction-fetch buffer: address width,
//   instruction width, reset fetch address and, when the misalignment check
//   is built in (FETCH_MISALIGN_CHECK_EN), the NOP encoding and the
//   alignment helper.
package fetch_buffer_pkg;

  localparam int XLEN_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [XLEN_WIDTH-1:0] CPU_START_ADDR = '0;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [INST_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  // Instructions are word aligned; any nonzero low bit is a misaligned PC.
  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return (pc_lsb != 2'b00);
  endfunction
`endif

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous DEPTH-entry FIFO holding fetched {pc, inst} entries.
//   Registered storage, head read directly from the storage slot (no bypass).
//   Flush and reset empty the FIFO and take priority over push and pop.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   flush      in   empty the FIFO this cycle
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   advance the head
//   count      out  number of stored entries (0..DEPTH)
//   head       out  entry at the head slot
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_clr;
  logic             w_push;
  logic             w_pop;

  assign w_clr  = rst | flush;
  assign w_push = push & ~w_clr;
  assign w_pop  = pop & ~w_clr;

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Instruction-fetch stage sitting right after the PC register. Issues one
//   instruction-memory read per accepted PC, captures the 1-cycle-latency
//   response into a DEPTH-entry FIFO of {pc, inst}, and hands entries to
//   decode with a valid/ready handshake. Backpressure goes to the PC through
//   pause; flush discards everything buffered or in flight.
//
//   Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned PC still takes
//   a credit but sends no memory read; the entry is a NOP with fault set.
//
// Ports
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   flush       in   discard buffered and in-flight fetches
//   pc          in   current PC
//   pause       out  hold the PC (no request this cycle)
//   imem_req    out  instruction-memory read strobe
//   imem_addr   out  read address (= pc)
//   imem_rdata  in   instruction word, valid the cycle after imem_req
//   out_valid   out  head entry valid
//   out_ready   in   decode accepts head
//   out_pc      out  head PC
//   out_inst    out  head instruction
//   out_fault   out  head misaligned flag (0 when the check is not built)
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [XLEN-1:0]       pc,
  output logic                  pause,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic                  out_fault
);

  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam int EW = 1 + XLEN + INST_WIDTH;
`else
  localparam int EW = XLEN + INST_WIDTH;
`endif
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  logic            r_inflight;
  logic [XLEN-1:0] r_req_pc;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic [EW-1:0]   w_head;
  logic [EW-1:0]   w_push_data;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;

  // out_valid is forced low while reset is held so no pop can occur then.
  assign w_valid = (w_count != '0) & ~rst;
  assign w_pop   = w_valid & out_ready;

  // Credit: entries stored plus the one in flight, minus what leaves now,
  // must leave a free slot for the response that this request will produce.
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue = ~rst & ~flush & (w_occ < DEPTH_OCC);

  assign pause     = ~w_issue;
  assign imem_addr = pc;
  assign w_push    = r_inflight & ~flush & ~rst;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_req_mis;

  assign imem_req = w_issue & ~is_misaligned(pc[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_mis <= 1'b0;
    end else if (w_issue) begin
      r_req_mis <= is_misaligned(pc[1:0]);
    end
  end

  // A misaligned request had no memory read; whatever rdata holds is ignored.
  assign w_push_data = {r_req_mis, r_req_pc, (r_req_mis ? INST_NOP : imem_rdata)};
  assign out_fault   = w_head[EW-1];
`else
  assign imem_req    = w_issue;
  assign w_push_data = {r_req_pc, imem_rdata};
  assign out_fault   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_req_pc   <= CPU_START_ADDR;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .count     (w_count),
    .head      (w_head)
  );

  assign out_valid = w_valid;
  assign out_inst  = w_head[INST_WIDTH-1:0];
  assign out_pc    = w_head[INST_WIDTH +: XLEN];

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] pc;
  logic        pause;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;

  logic [31:0] flush_tgt;
  logic [31:0] exp_pc;
  int          checks;
  int          failures;

  fetch_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .pc         (pc),
    .pause      (pause),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .out_fault  (out_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // PC register model: resets to start address, redirects on flush, steps when not paused.
  always @(posedge clk) begin
    if (rst)        pc <= 32'h0;
    else if (flush) pc <= flush_tgt;
    else if (!pause) pc <= pc + 32'd4;
  end

  // Instruction memory with one cycle of read latency; garbage when not read.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? inst_of(imem_addr) : 32'hBAD0_BAD0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    flush_tgt = 32'h0;

    // Reset state
    repeat (3) tick();
    settle();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_pause", 32'(pause),     32'd1);

    // Streaming with out_ready held high
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    settle();
    check("s_c0_req",   32'(imem_req),  32'd1);
    check("s_c0_addr",  imem_addr,      32'h0);
    check("s_c0_valid", 32'(out_valid), 32'd0);
    tick(); settle();
    check("s_c1_valid", 32'(out_valid), 32'd0);
    check("s_c1_addr",  imem_addr,      32'h4);
    tick(); settle();
    check("s_c2_valid", 32'(out_valid), 32'd1);
    check("s_c2_pc",    out_pc,         32'h0);
    check("s_c2_inst",  out_inst,       inst_of(32'h0));
    check("s_c2_fault", 32'(out_fault), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(); settle();
      check("s_valid", 32'(out_valid), 32'd1);
      check("s_pc",    out_pc,         32'(4 * k));
      check("s_inst",  out_inst,       inst_of(32'(4 * k)));
      check("s_pause", 32'(pause),     32'd0);
    end

    // Backpressure from the start: buffer fills with 0x0, 0x4
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    settle();
    tick(); settle();
    tick();
    rst = 1'b0;
    settle();
    check("bp_c0_pause", 32'(pause), 32'd0);
    check("bp_c0_addr",  imem_addr,  32'h0);
    tick(); settle();
    check("bp_c1_pause", 32'(pause), 32'd0);
    check("bp_c1_addr",  imem_addr,  32'h4);
    for (int c = 2; c <= 5; c++) begin
      tick(); settle();
      check("bp_pause", 32'(pause),     32'd1);
      check("bp_req",   32'(imem_req),  32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_head",  out_pc,         32'h0);
      check("bp_addr",  imem_addr,      32'h8);
    end
    tick();
    out_ready = 1'b1;
    settle();
    check("drain_pc0",  out_pc,        32'h0);
    check("drain_req0", 32'(imem_req), 32'd1);
    check("drain_addr0", imem_addr,    32'h8);
    for (int k = 1; k <= 3; k++) begin
      tick(); settle();
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc",    out_pc,         32'(4 * k));
      check("drain_inst",  out_inst,       inst_of(32'(4 * k)));
      check("drain_req",   32'(imem_req),  32'd1);
      check("drain_addr",  imem_addr,      32'(8 + 4 * k));
    end

    // out_ready toggling 0,1,0,1: head holds on 0, advances by 4 on 1
    exp_pc = 32'h10;
    for (int i = 0; i < 20; i++) begin
      tick();
      out_ready = (i % 2 == 1);
      settle();
      check("tog_valid", 32'(out_valid), 32'd1);
      check("tog_pc",    out_pc,         exp_pc);
      if (out_ready) exp_pc = exp_pc + 32'd4;
    end

    // Flush with one entry buffered (0x38) and 0x3C in flight, concurrent pop
    tick();
    flush = 1'b1;
    flush_tgt = 32'h200;
    out_ready = 1'b1;
    settle();
    check("fl_valid_pre", 32'(out_valid), 32'd1);
    check("fl_head_pre",  out_pc,         32'h38);
    check("fl_pause",     32'(pause),     32'd1);
    check("fl_req",       32'(imem_req),  32'd0);
    tick();
    flush = 1'b0;
    settle();
    check("fl_valid_post", 32'(out_valid), 32'd0);
    check("fl_req_post",   32'(imem_req),  32'd1);
    check("fl_addr_post",  imem_addr,      32'h200);
    tick(); settle();
    check("fl_valid_f2", 32'(out_valid), 32'd0);
    tick(); settle();
    check("fl_valid_f3", 32'(out_valid), 32'd1);
    check("fl_pc_f3",    out_pc,         32'h200);
    check("fl_inst_f3",  out_inst,       inst_of(32'h200));

    // Reset mid-stream with one entry buffered and one in flight
    rst = 1'b1;
    settle();
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_pause", 32'(pause),     32'd1);
    check("mr_req",   32'(imem_req),  32'd0);
    tick(); settle();
    check("mr_valid2", 32'(out_valid), 32'd0);
    check("mr_pause2", 32'(pause),     32'd1);
    tick();
    rst = 1'b0;
    settle();
    check("mr_req_restart",  32'(imem_req), 32'd1);
    check("mr_addr_restart", imem_addr,     32'h0);
    tick(); settle();
    check("mr_valid_r1", 32'(out_valid), 32'd0);
    tick(); settle();
    check("mr_valid_r2", 32'(out_valid), 32'd1);
    check("mr_pc_r2",    out_pc,         32'h0);
    check("mr_inst_r2",  out_inst,       inst_of(32'h0));

`ifdef FETCH_MISALIGN_CHECK_EN
    // Redirect to a misaligned PC
    tick();
    flush = 1'b1;
    flush_tgt = 32'h6;
    settle();
    tick();
    flush = 1'b0;
    settle();
    check("mis_addr",  imem_addr,      32'h6);
    check("mis_req",   32'(imem_req),  32'd0);
    check("mis_pause", 32'(pause),     32'd0);
    tick(); settle();
    tick(); settle();
    check("mis_valid", 32'(out_valid), 32'd1);
    check("mis_pc",    out_pc,         32'h6);
    check("mis_inst",  out_inst,       32'h0000_0013);
    check("mis_fault", 32'(out_fault), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
